// File: rtl/keypad_lock_ctrl.sv
// Keypad code-lock controller: N-digit entry, check with retry limit, timed unlock and alarm lockout.
// Optional code reprogramming from OPEN is compiled in when CODE_PROG_EN is defined.
module keypad_lock_ctrl #(
  parameter int N_DIGITS    = 4,
  parameter int DIGIT_W     = 4,
  parameter int MAX_TRIES   = 3,
  parameter int UNLOCK_CYC  = 950,
  parameter int LOCKOUT_CYC = 1900,
  parameter logic [N_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = {4'd1, 4'd2, 4'd3, 4'd4}
) (
  input  logic                           clk,
  input  logic                           clr_n,
  input  logic                           key_valid,
  input  logic [DIGIT_W-1:0]             key_code,
  input  logic                           enter,
  input  logic                           prog,
  output logic                           unlock,
  output logic                           alarm,
  output logic [$clog2(N_DIGITS+1)-1:0]  entry_cnt,
  output logic [N_DIGITS*DIGIT_W-1:0]    disp_digits,
  output logic [2:0]                     state
);

  localparam int BUF_W   = N_DIGITS * DIGIT_W;
  localparam int CNT_W   = $clog2(N_DIGITS + 1);
  localparam int TRY_W   = $clog2(MAX_TRIES + 1);
  localparam int MAX_CYC = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_LOCKOUT = 3'd4,
    S_PROG    = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [BUF_W-1:0]   code_q;
  logic               unlock_q, alarm_q;

  logic               buf_full;
  logic               digit_ok;
  logic               code_match;
  logic [BUF_W-1:0]   buf_shifted;

  assign buf_full    = (cnt_q == CNT_W'(N_DIGITS));
  assign digit_ok    = key_valid && (key_code <= DIGIT_W'(9)) && !buf_full;
  assign code_match  = buf_full && (buf_q == code_q);
  assign buf_shifted = {buf_q[BUF_W-DIGIT_W-1:0], key_code};

`ifdef CODE_PROG_EN
  logic [BUF_W-1:0] code_d;

  // NOTE: the stored code is a plain register, so it takes DEFAULT_CODE on reset like any other state.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) code_q <= DEFAULT_CODE;
    else        code_q <= code_d;
  end
`else
  logic prog_unused;
  assign prog_unused = prog;
  assign code_q      = DEFAULT_CODE;
`endif

  // NOTE: every variable is defaulted first so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    tries_d = tries_q;
    timer_d = timer_q;
`ifdef CODE_PROG_EN
    code_d  = code_q;
`endif
    case (state_q)
      S_IDLE, S_ENTRY: begin
        if (enter) begin
          state_d = S_CHECK;
        end else if (digit_ok) begin
          buf_d   = buf_shifted;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_ENTRY;
        end
      end
      S_CHECK: begin
        buf_d = '0;
        cnt_d = '0;
        if (code_match) begin
          state_d = S_OPEN;
          tries_d = '0;
          timer_d = TMR_W'(UNLOCK_CYC - 1);
        end else if (tries_q >= TRY_W'(MAX_TRIES - 1)) begin
          state_d = S_LOCKOUT;
          tries_d = TRY_W'(MAX_TRIES);
          timer_d = TMR_W'(LOCKOUT_CYC - 1);
        end else begin
          state_d = S_IDLE;
          tries_d = tries_q + TRY_W'(1);
        end
      end
      S_OPEN: begin
        if (enter) begin
          state_d = S_IDLE;
          timer_d = '0;
`ifdef CODE_PROG_EN
        end else if (prog) begin
          state_d = S_PROG;
          timer_d = '0;
          buf_d   = '0;
          cnt_d   = '0;
`endif
        end else if (timer_q == '0) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      S_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = S_IDLE;
          tries_d = '0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
`ifdef CODE_PROG_EN
      S_PROG: begin
        if (enter) begin
          if (buf_full) code_d = buf_q;
          buf_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (digit_ok) begin
          buf_d = buf_shifted;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        buf_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= S_IDLE;
      buf_q    <= '0;
      cnt_q    <= '0;
      tries_q  <= '0;
      timer_q  <= '0;
      unlock_q <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      tries_q  <= tries_d;
      timer_q  <= timer_d;
      unlock_q <= (state_d == S_OPEN);
      alarm_q  <= (state_d == S_LOCKOUT);
    end
  end

  assign unlock      = unlock_q;
  assign alarm       = alarm_q;
  assign entry_cnt   = cnt_q;
  assign disp_digits = buf_q;
  assign state       = state_q;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Self-checking bench for keypad_lock_ctrl: vector table plus hand-written timing,
// lockout, async-reset and (with CODE_PROG_EN) reprogramming sequences.
module tb_keypad_lock_ctrl;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        enter = 1'b0;
  logic        prog = 1'b0;
  logic        unlock, alarm;
  logic [2:0]  entry_cnt;
  logic [15:0] disp_digits;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_ENTRY = 3'd1, ST_CHECK = 3'd2,
                         ST_OPEN = 3'd3, ST_LOCK = 3'd4, ST_PROG = 3'd5;

  keypad_lock_ctrl dut (
    .clk(clk), .clr_n(clr_n), .key_valid(key_valid), .key_code(key_code),
    .enter(enter), .prog(prog), .unlock(unlock), .alarm(alarm),
    .entry_cnt(entry_cnt), .disp_digits(disp_digits), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        kv;
    logic [3:0]  kc;
    logic        en;
    logic [2:0]  st;
    logic [2:0]  cnt;
    logic [15:0] disp;
    logic        unl;
    logic        alm;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic kv, input logic [3:0] kc, input logic en, input logic pr);
    @(negedge clk);
    key_valid = kv; key_code = kc; enter = en; prog = pr;
    @(posedge clk);
    #1;
    key_valid = 1'b0; enter = 1'b0; prog = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic key(input logic [3:0] k);
    step(1'b1, k, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_n = 1'b0;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
  endtask

  // Four digits MS first, enter, then one cycle so the post-CHECK state is visible.
  task automatic try_code(input logic [15:0] c);
    key(c[15:12]); key(c[11:8]); key(c[7:4]); key(c[3:0]);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    idle();
  endtask

  task automatic add(input logic kv, input logic [3:0] kc, input logic en,
                     input logic [2:0] st, input logic [2:0] cnt, input logic [15:0] disp,
                     input logic unl, input logic alm);
    vec_t v;
    v.kv = kv; v.kc = kc; v.en = en; v.st = st; v.cnt = cnt;
    v.disp = disp; v.unl = unl; v.alm = alm;
    vecs.push_back(v);
  endtask

  initial begin
    int n;

    //   kv  kc     en    state     cnt   disp      unl   alm
    add(0, 4'd0, 0, ST_IDLE,  3'd0, 16'h0000, 0, 0);
    add(1, 4'd1, 0, ST_ENTRY, 3'd1, 16'h0001, 0, 0);
    add(1, 4'd2, 0, ST_ENTRY, 3'd2, 16'h0012, 0, 0);
    add(1, 4'd3, 0, ST_ENTRY, 3'd3, 16'h0123, 0, 0);
    add(0, 4'd0, 1, ST_CHECK, 3'd3, 16'h0123, 0, 0);
    add(0, 4'd0, 0, ST_IDLE,  3'd0, 16'h0000, 0, 0);  // short code fails, tries=1
    add(1, 4'd1, 0, ST_ENTRY, 3'd1, 16'h0001, 0, 0);
    add(1, 4'd2, 0, ST_ENTRY, 3'd2, 16'h0012, 0, 0);
    add(1, 4'd3, 0, ST_ENTRY, 3'd3, 16'h0123, 0, 0);
    add(1, 4'd4, 0, ST_ENTRY, 3'd4, 16'h1234, 0, 0);
    add(1, 4'd5, 0, ST_ENTRY, 3'd4, 16'h1234, 0, 0);  // fifth digit ignored
    add(1, 4'hB, 0, ST_ENTRY, 3'd4, 16'h1234, 0, 0);  // non-decimal key ignored
    add(0, 4'd7, 0, ST_ENTRY, 3'd4, 16'h1234, 0, 0);  // no key_valid
    add(0, 4'd0, 1, ST_CHECK, 3'd4, 16'h1234, 0, 0);
    add(0, 4'd0, 0, ST_OPEN,  3'd0, 16'h0000, 1, 0);  // match, tries cleared
    add(1, 4'd7, 0, ST_OPEN,  3'd0, 16'h0000, 1, 0);  // keys ignored while open
    add(0, 4'd0, 1, ST_IDLE,  3'd0, 16'h0000, 0, 0);  // early relock
    add(1, 4'd1, 0, ST_ENTRY, 3'd1, 16'h0001, 0, 0);
    add(1, 4'd2, 0, ST_ENTRY, 3'd2, 16'h0012, 0, 0);
    add(1, 4'd3, 0, ST_ENTRY, 3'd3, 16'h0123, 0, 0);
    add(1, 4'd5, 1, ST_CHECK, 3'd3, 16'h0123, 0, 0);  // enter wins, digit dropped
    add(0, 4'd0, 0, ST_IDLE,  3'd0, 16'h0000, 0, 0);  // tries=1
    add(1, 4'hB, 0, ST_IDLE,  3'd0, 16'h0000, 0, 0);
    add(0, 4'd0, 1, ST_CHECK, 3'd0, 16'h0000, 0, 0);
    add(0, 4'd0, 0, ST_IDLE,  3'd0, 16'h0000, 0, 0);  // tries=2
    add(0, 4'd0, 1, ST_CHECK, 3'd0, 16'h0000, 0, 0);
    add(0, 4'd0, 0, ST_LOCK,  3'd0, 16'h0000, 0, 1);  // third failure
    add(1, 4'd1, 0, ST_LOCK,  3'd0, 16'h0000, 0, 1);

    clr_n = 1'b0;
    #1;
    check("reset_state", state, ST_IDLE);
    check("reset_unlock", unlock, 0);
    check("reset_alarm", alarm, 0);
    check("reset_cnt", entry_cnt, 0);
    check("reset_disp", disp_digits, 0);
    do_reset();

    foreach (vecs[i]) begin
      step(vecs[i].kv, vecs[i].kc, vecs[i].en, 1'b0);
      check($sformatf("v%0d_state", i), state, vecs[i].st);
      check($sformatf("v%0d_cnt", i), entry_cnt, vecs[i].cnt);
      check($sformatf("v%0d_disp", i), disp_digits, vecs[i].disp);
      check($sformatf("v%0d_unlock", i), unlock, vecs[i].unl);
      check($sformatf("v%0d_alarm", i), alarm, vecs[i].alm);
    end

    // Unlock latency and duration.
    do_reset();
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    check("t1_check_state", state, ST_CHECK);
    check("t1_check_unlock", unlock, 0);
    idle();
    check("t1_unlock_t2", unlock, 1);
    n = 1;
    for (int i = 0; i < 3000; i++) begin
      idle();
      if (!unlock) break;
      n++;
    end
    check("t1_unlock_len", n, 950);
    check("t1_end_state", state, ST_IDLE);

    // Lockout duration with inputs ignored meanwhile.
    try_code(16'h9999);
    try_code(16'h9999);
    check("t3_tries2_state", state, ST_IDLE);
    key(4'd9); key(4'd9); key(4'd9); key(4'd9);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    idle();
    check("t3_alarm_on", alarm, 1);
    check("t3_no_unlock", unlock, 0);
    n = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i >= 5 && i <= 8) key(4'(i - 4));
      else if (i == 9) step(1'b0, 4'd0, 1'b1, 1'b0);
      else idle();
      if (unlock) begin
        check("t3_unlock_in_lockout", unlock, 0);
        break;
      end
      if (!alarm) break;
      n++;
    end
    check("t3_alarm_len", n, 1900);
    check("t3_end_state", state, ST_IDLE);
    check("t3_end_cnt", entry_cnt, 0);
    try_code(16'h9999);
    check("t3_tries_cleared", state, ST_IDLE);
    try_code(16'h1234);
    check("t3_open_after", unlock, 1);

    // Async reset mid-OPEN.
    repeat (3) idle();
    @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    check("t6_open_unlock", unlock, 0);
    check("t6_open_state", state, ST_IDLE);
    @(posedge clk);
    #1;
    check("t6_open_hold", {unlock, alarm, state, entry_cnt}, 0);
    @(negedge clk);
    clr_n = 1'b1;

    // Async reset mid-LOCKOUT.
    try_code(16'h0000); try_code(16'h0000); try_code(16'h0000);
    check("t6_lock_alarm", alarm, 1);
    repeat (4) idle();
    @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    check("t6_lock_alarm_drop", alarm, 0);
    check("t6_lock_state", state, ST_IDLE);
    @(negedge clk);
    clr_n = 1'b1;
    try_code(16'h1234);
    check("t6_fresh_tries", unlock, 1);

`ifdef CODE_PROG_EN
    step(1'b0, 4'd0, 1'b0, 1'b1);
    check("t5_prog_state", state, ST_PROG);
    check("t5_prog_unlock", unlock, 0);
    key(4'd5); key(4'd6); key(4'd7); key(4'd8);
    check("t5_prog_disp", disp_digits, 16'h5678);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    check("t5_commit_state", state, ST_IDLE);
    try_code(16'h5678);
    check("t5_new_opens", unlock, 1);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    try_code(16'h1234);
    check("t5_old_fails", {unlock, state}, {1'b0, ST_IDLE});
    do_reset();
    try_code(16'h1234);
    check("t5_reset_default", unlock, 1);
`else
    step(1'b0, 4'd0, 1'b0, 1'b1);
    check("prog_ignored_state", state, ST_OPEN);
    check("prog_ignored_unlock", unlock, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
